// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the UART byte bridge.
// Holds RX/TX state encodings and bit-timing helper functions.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_WAITLOW
  } tx_state_e;

  function automatic int clks_per_bit(
    input int freq_hz,
    input int baud
  );
    return freq_hz / baud;
  endfunction

  function automatic int cnt_width(input int clks);
    return $clog2(clks) + 1;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver: 2-flop synchronizer plus RX FSM.
// Ports: clk, reset, rx_i, load_o, data_o[7:0], frame_err_o.
module uart_byte_rx
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic       load_o,
  output logic [7:0] data_o,
  output logic       frame_err_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync_q;
  logic          rxs_q;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          load_q, load_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      data_q <= '0;
      load_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= rx_i;
      rxs_q  <= sync_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      data_q <= data_d;
      load_q <= load_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    data_d = data_q;
    load_d = 1'b0;
    ferr_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs_q) st_d = RX_START;
      end
      RX_START: begin
        // mid-start sample: high means glitch
        if (cnt_q == HALF) begin
          cnt_d = '0;
          st_d  = rxs_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (rxs_q) begin
            data_d = sh_q;
            load_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign load_o      = load_q;
  assign data_o      = data_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_byte_bridge.sv
// UART 8N1 <-> byte bridge in front of the GPIO port block.
// Ports: clk, reset, rx, tx, load, datain, ready, enout, dataout, frame_err.
module uart_byte_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic       load,
  output logic [7:0] datain,
  output logic       ready,
  input  logic       enout,
  input  logic [7:0] dataout,
  output logic       frame_err
);

  localparam int CPB =
    clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CW = cnt_width(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx),
    .load_o     (load),
    .data_o     (datain),
    .frame_err_o(frame_err)
  );

  tx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= TX_WAITLOW;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      tx_q  <= 1'b1;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      tx_q  <= tx_d;
    end
  end

  // tx_d is the line level for the cycle after
  // the edge, so the line is a clean flop output
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    tx_d  = tx_q;
    unique case (st_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (enout) begin
          sh_d = dataout;
          st_d = TX_START;
          tx_d = 1'b0;
        end
      end
      TX_START: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = TX_DATA;
          tx_d  = sh_q[0];
        end
      end
      TX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            st_d = TX_STOP;
            tx_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          st_d  = TX_WAITLOW;
        end
      end
      TX_WAITLOW: begin
        // a held enout must drop before re-arming
        cnt_d = '0;
        if (!enout) st_d = TX_IDLE;
      end
      default: st_d = TX_WAITLOW;
    endcase
  end

  assign ready = (st_q == TX_IDLE);
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Self-checking bench for uart_byte_bridge.
// Drives UART frames and the port-block handshake.
module tb_uart_byte_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       enout = 1'b0;
  logic [7:0] dataout = '0;
  logic       tx;
  logic       load;
  logic [7:0] datain;
  logic       ready;
  logic       frame_err;

  uart_byte_bridge #(
    .CLK_FREQ_HZ(1000000),
    .BAUD       (100000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .load     (load),
    .datain   (datain),
    .ready    (ready),
    .enout    (enout),
    .dataout  (dataout),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // receive-side reference: bytes owed to the port block
  logic [7:0] exp_q[$];
  logic [7:0] last_good = '0;
  logic [7:0] mon_e;
  int n_load = 0;
  int n_ferr = 0;
  int exp_load = 0;
  int exp_ferr = 0;
  int load_cyc = 0;

  always @(negedge clk) begin
    if (!reset && (load || frame_err)) begin
      chk("strobe_excl", {31'b0, load & frame_err}, 0);
      if (load) begin
        n_load++;
        load_cyc = cyc;
        chk("load_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("datain", {24'b0, datain}, {24'b0, mon_e});
          last_good = mon_e;
        end
      end
      if (frame_err) begin
        n_ferr++;
        chk("ferr_hold", {24'b0, datain},
            {24'b0, last_good});
      end
    end
  end

  task automatic send_rx(
    input logic [7:0] b,
    input logic       stop
  );
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back(b);
      exp_load++;
    end else begin
      exp_ferr++;
    end
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_ready(
    input  int lim,
    output bit ok
  );
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // port-block model: enout one cycle after ready,
  // held for 'hold' cycles in total
  task automatic send_tx(
    input logic [7:0] b,
    input int         hold
  );
    bit         ok;
    logic [9:0] fr;
    logic [9:0] v;
    logic [9:0] ev;
    int         hi;
    int         dup;
    fr = {1'b1, b, 1'b0};
    wait_ready(50, ok);
    chk("tx_rdy_wait", {31'b0, ok}, 1);
    if (!ok) return;
    @(negedge clk);
    enout = 1'b1;
    dataout = b;
    @(negedge clk);
    chk("rdy_fall", {31'b0, ready}, 0);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 10; j++) begin
        v[j] = tx;
        hi += int'(ready);
        enout = (k * 10 + j + 1 < hold);
        @(negedge clk);
      end
      ev = {10{fr[k]}};
      chk("tx_bit", {22'b0, v}, {22'b0, ev});
    end
    chk("tx_rdy_low", hi, 0);
    dup = 0;
    for (int m = 100; m < hold; m++) begin
      dup += int'(!tx) + int'(ready);
      enout = (m + 1 < hold);
      @(negedge clk);
    end
    chk("tx_nodup", dup, 0);
    enout = 1'b0;
    wait_ready(5, ok);
    chk("rdy_back", {31'b0, ok}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t limit", $time);
    $fatal(1);
  end

  int         t0;
  int         lat;
  bit         ok;
  logic [7:0] bt;
  logic [7:0] br;
  logic [9:0] frr;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_load", {31'b0, load}, 0);
    chk("rst_datain", {24'b0, datain}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_ferr", {31'b0, frame_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single good byte with latency
    t0 = cyc;
    send_rx(8'h52, 1'b1);
    repeat (15) @(negedge clk);
    chk("t1_nload", n_load, exp_load);
    lat = load_cyc - t0;
    chk("t1_lat", (lat >= 96 && lat <= 98) ? 97 : lat,
        97);

    // short glitch, then bad stop bit
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_glitch_ld", n_load, exp_load);
    chk("t2_glitch_fe", n_ferr, exp_ferr);
    send_rx(8'hA5, 1'b0);
    repeat (30) @(negedge clk);
    chk("t2_nferr", n_ferr, exp_ferr);
    chk("t2_nload", n_load, exp_load);
    chk("t2_hold", {24'b0, datain}, 32'h52);

    // handshake and held enout
    send_tx(8'h2F, 1);
    send_tx(8'h11, 200);

    // full duplex
    fork
      send_rx(8'hC3, 1'b1);
      begin
        repeat (20) @(negedge clk);
        send_tx(8'h3C, 1);
      end
    join
    repeat (20) @(negedge clk);
    chk("t5_nload", n_load, exp_load);

    // random full-duplex traffic
    for (int it = 0; it < 5; it++) begin
      br = 8'($urandom_range(0, 255));
      bt = 8'($urandom_range(0, 255));
      fork
        send_rx(br, $urandom_range(0, 3) != 0);
        begin
          repeat ($urandom_range(0, 60))
            @(negedge clk);
          send_tx(bt, int'($urandom_range(1, 8)));
        end
      join
      repeat (15) @(negedge clk);
      chk("rnd_nload", n_load, exp_load);
      chk("rnd_nferr", n_ferr, exp_ferr);
    end

    // reset during TX bit 4 / RX bit 3
    wait_ready(50, ok);
    chk("t6_rdy", {31'b0, ok}, 1);
    bt = 8'($urandom_range(0, 255));
    br = 8'($urandom_range(0, 255));
    frr = {1'b1, br, 1'b0};
    @(negedge clk);
    for (int m = 0; m < 55; m++) begin
      enout = (m == 0);
      dataout = bt;
      rx = (m < 10) ? 1'b1 : frr[(m - 10) / 10];
      @(negedge clk);
    end
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("t6_tx", {31'b0, tx}, 1);
    chk("t6_ready", {31'b0, ready}, 0);
    chk("t6_load", {31'b0, load}, 0);
    chk("t6_ferr", {31'b0, frame_err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_good = '0;
    repeat (3) @(negedge clk);
    chk("t6_noload", n_load, exp_load);
    chk("t6_noferr", n_ferr, exp_ferr);
    send_rx(8'h01, 1'b1);
    repeat (15) @(negedge clk);
    chk("t6_nload", n_load, exp_load);
    chk("t6_datain", {24'b0, datain}, 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
